// File: rtl/payload_buffer_scheduler.sv
// Control-path arbiter for the shared payload buffer: one packet chain in flight at a time,
// round-robin between the ingress writer (slot 0) and the egress readers (slots 1..NUM_READERS).
module payload_buffer_scheduler #(
    parameter int NUM_READERS = 4,
    parameter int ADDR_W      = 8,
    parameter int CAP_W       = 9
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_req,
    input  logic [CAP_W-1:0]              wr_blocks,
    input  logic                          wr_valid,
    input  logic                          wr_last,
    output logic                          wr_gnt,
    input  logic [NUM_READERS-1:0]        rd_req,
    input  logic [NUM_READERS*ADDR_W-1:0] rd_addr,
    input  logic [NUM_READERS-1:0]        rd_destructive,
    input  logic [NUM_READERS-1:0]        rd_ready,
    output logic [NUM_READERS-1:0]        rd_gnt,
    output logic [NUM_READERS-1:0]        rd_valid,
    output logic                          buf_enable,
    output logic                          buf_read_write,
    output logic [ADDR_W-1:0]             buf_rd_address,
    output logic                          buf_rd_is_first,
    output logic                          buf_rd_is_destructive,
    input  logic                          buf_rd_is_last,
    input  logic [CAP_W-1:0]              buf_capacity
);

    localparam int NSLOT = NUM_READERS + 1;
    localparam int PTR_W = $clog2(NSLOT);
    localparam int IDX_W = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_FIRST = 2'd2,
        RD       = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [PTR_W-1:0]        ptr_r;
    logic [PTR_W-1:0]        ptr_s;
    logic [IDX_W-1:0]        sel_r;
    logic [IDX_W-1:0]        sel_s;
    logic                    pending_r;
    logic                    pending_s;
    logic                    wr_gnt_r;
    logic                    wr_gnt_s;
    logic [NUM_READERS-1:0]  rd_gnt_r;
    logic [NUM_READERS-1:0]  rd_gnt_s;
    logic                    rw_r;
    logic                    rw_s;
    logic [ADDR_W-1:0]       addr_r;
    logic [ADDR_W-1:0]       addr_s;
    logic                    dest_r;
    logic                    dest_s;

    logic [NSLOT-1:0]        elig_s;
    logic [PTR_W:0]          sum_s;
    logic [PTR_W-1:0]        slot_s;
    logic                    found_s;
    logic [PTR_W-1:0]        win_s;
    logic [PTR_W-1:0]        win_next_s;
    logic [NUM_READERS-1:0]  win_onehot_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [ADDR_W-1:0]       win_addr_s;
    logic                    win_dest_s;
    logic                    sel_ready_s;

    assign sel_ready_s = rd_ready[sel_r];

    // Round-robin search from the pointer; a writer that cannot fit its packet is simply skipped.
    always_comb begin
        elig_s        = {NSLOT{1'b0}};
        elig_s[0]     = wr_req & (wr_blocks != {CAP_W{1'b0}}) & (buf_capacity >= wr_blocks);
        elig_s[NSLOT-1:1] = rd_req;
        sum_s         = {(PTR_W+1){1'b0}};
        slot_s        = {PTR_W{1'b0}};
        found_s       = 1'b0;
        win_s         = {PTR_W{1'b0}};
        for (int k = 0; k < NSLOT; k++) begin
            sum_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
            if (sum_s >= (PTR_W+1)'(NSLOT)) begin
                sum_s = sum_s - (PTR_W+1)'(NSLOT);
            end else begin
                sum_s = sum_s;
            end
            slot_s = sum_s[PTR_W-1:0];
            if (!found_s && elig_s[slot_s]) begin
                found_s = 1'b1;
                win_s   = slot_s;
            end else begin
                found_s = found_s;
            end
        end
        if (win_s == PTR_W'(NSLOT - 1)) begin
            win_next_s = {PTR_W{1'b0}};
        end else begin
            win_next_s = win_s + PTR_W'(1);
        end
    end

    // Decode the winning slot into the reader's index, head address and destructive flag.
    always_comb begin
        win_onehot_s = {NUM_READERS{1'b0}};
        win_idx_s    = {IDX_W{1'b0}};
        win_addr_s   = {ADDR_W{1'b0}};
        win_dest_s   = 1'b0;
        for (int i = 0; i < NUM_READERS; i++) begin
            if (win_s == PTR_W'(i + 1)) begin
                win_onehot_s[i] = 1'b1;
                win_idx_s       = IDX_W'(i);
                win_addr_s      = rd_addr[i*ADDR_W +: ADDR_W];
                win_dest_s      = rd_destructive[i];
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic; read/write direction, address and destructive flag only change at a grant.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        pending_s = pending_r;
        wr_gnt_s  = wr_gnt_r;
        rd_gnt_s  = rd_gnt_r;
        rw_s      = rw_r;
        addr_s    = addr_r;
        dest_s    = dest_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    ptr_s = win_next_s;
                    if (win_s == {PTR_W{1'b0}}) begin
                        state_s  = WRITE;
                        wr_gnt_s = 1'b1;
                        rw_s     = 1'b1;
                    end else begin
                        state_s  = RD_FIRST;
                        rd_gnt_s = win_onehot_s;
                        sel_s    = win_idx_s;
                        addr_s   = win_addr_s;
                        dest_s   = win_dest_s;
                        rw_s     = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (wr_valid && wr_last) begin
                    state_s  = IDLE;
                    wr_gnt_s = 1'b0;
                end else begin
                    state_s = WRITE;
                end
            end
            RD_FIRST: begin
                if (sel_ready_s) begin
                    state_s   = RD;
                    pending_s = 1'b1;
                end else begin
                    state_s = RD_FIRST;
                end
            end
            RD: begin
                // The consume of the last block is the commit access; release on the following edge.
                if (pending_r && sel_ready_s && buf_rd_is_last) begin
                    state_s   = IDLE;
                    pending_s = 1'b0;
                    rd_gnt_s  = {NUM_READERS{1'b0}};
                end else begin
                    state_s = RD;
                end
            end
            default: begin
                state_s   = IDLE;
                pending_s = 1'b0;
                wr_gnt_s  = 1'b0;
                rd_gnt_s  = {NUM_READERS{1'b0}};
            end
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= {PTR_W{1'b0}};
            sel_r     <= {IDX_W{1'b0}};
            pending_r <= 1'b0;
            wr_gnt_r  <= 1'b0;
            rd_gnt_r  <= {NUM_READERS{1'b0}};
            rw_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            dest_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            sel_r     <= sel_s;
            pending_r <= pending_s;
            wr_gnt_r  <= wr_gnt_s;
            rd_gnt_r  <= rd_gnt_s;
            rw_r      <= rw_s;
            addr_r    <= addr_s;
            dest_r    <= dest_s;
        end
    end

    // Buffer enable follows the owner's strobe in the same cycle so stalls never issue an access.
    always_comb begin
        buf_enable      = 1'b0;
        buf_rd_is_first = 1'b0;
        rd_valid        = {NUM_READERS{1'b0}};
        case (state_r)
            IDLE: begin
                buf_enable = 1'b0;
            end
            WRITE: begin
                buf_enable = wr_valid;
            end
            RD_FIRST: begin
                buf_enable      = sel_ready_s;
                buf_rd_is_first = 1'b1;
            end
            RD: begin
                buf_enable = sel_ready_s;
                rd_valid   = rd_gnt_r & {NUM_READERS{pending_r}};
            end
            default: begin
                buf_enable = 1'b0;
            end
        endcase
    end

    assign wr_gnt                = wr_gnt_r;
    assign rd_gnt                = rd_gnt_r;
    assign buf_read_write        = rw_r;
    assign buf_rd_address        = addr_r;
    assign buf_rd_is_destructive = dest_r;

endmodule

// File: doc/payload_buffer_scheduler.md
Name: payload_buffer_scheduler

Overview:
Sequences all accesses to the shared payload buffer, so that only one packet chain is in flight at a time. It arbitrates between one ingress writer and NUM_READERS egress readers, with round-robin order and packet-granularity grants. While a requester holds the grant, the block drives the buffer's enable, readWrite, address, isFirst and isDestructive controls. It sits between the packet dispatcher front end and the payload buffer. Data and write addresses pass from the buffer straight to the requesters; only control goes through this block.

Parameters:
NUM_READERS, 4, number of egress read requesters (1..8)
ADDR_W, 8, buffer block address width
CAP_W, 9, capacity/count width (ADDR_W+1)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
wr_req  in  1  writer requests a grant for one packet
wr_blocks  in  CAP_W  blocks the packet needs, stable while wr_req=1
wr_valid  in  1  writer presents a block this cycle
wr_last  in  1  qualifies wr_valid; final block of the packet
wr_gnt  out  1  writer owns the buffer
rd_req  in  NUM_READERS  per-reader request
rd_addr  in  NUM_READERS*ADDR_W  head address per reader, stable while rd_req=1
rd_destructive  in  NUM_READERS  per-reader destructive flag
rd_ready  in  NUM_READERS  reader can accept a block
rd_gnt  out  NUM_READERS  one-hot reader grant
rd_valid  out  NUM_READERS  one-hot: buffer output holds a block for the granted reader
buf_enable  out  1  buffer enable
buf_read_write  out  1  1=write, 0=read
buf_rd_address  out  ADDR_W  head address to buffer
buf_rd_is_first  out  1  first read of chain
buf_rd_is_destructive  out  1  destructive read
buf_rd_is_last  in  1  isLast of the block currently on the buffer output
buf_capacity  in  CAP_W  free blocks in the buffer

Behaviour:
- States: IDLE, WRITE, RD_FIRST, RD.
- Reset: state IDLE; round-robin pointer 0; pending flag 0; all outputs 0.
- Reset mid-packet aborts the packet silently and returns to IDLE; no drain cycle is issued.
- IDLE arbitration:
  - Slots are 0=writer, 1..NUM_READERS=readers.
  - Search starts at the pointer and wraps.
  - The writer is eligible only if wr_req=1, wr_blocks!=0 and buf_capacity>=wr_blocks.
  - An ineligible writer is skipped; it does not block readers.
  - The grant registers at the clock edge: wr_gnt/rd_gnt and the new state are visible the cycle after the request. Arbitration latency is 1 cycle.
  - On a grant, the pointer becomes the granted slot+1, modulo NUM_READERS+1.
  - No request: remain in IDLE with buf_enable=0.
- WRITE:
  - buf_read_write=1; buf_enable=wr_valid, combinational.
  - On wr_valid&wr_last: clear wr_gnt and go to IDLE next cycle.
  - wr_valid while not granted is ignored.
- RD_FIRST (reader g):
  - buf_read_write=0; buf_rd_is_first=1.
  - buf_rd_address=rd_addr[g]; buf_rd_is_destructive=rd_destructive[g].
  - buf_enable=rd_ready[g].
  - When enabled, set pending and go to RD.
- RD:
  - buf_rd_is_first=0; buf_rd_is_destructive stays registered from the grant.
  - rd_valid[g]=pending.
  - buf_enable=rd_ready[g]. The buffer holds its output while enable=0, so pending persists across stalls.
  - Consume = pending&rd_ready[g]. A consume issues the next read in the same cycle.
  - Consume with buf_rd_is_last=1: that enabled cycle is the commit cycle, which applies the buffer's TTL decrement or free to the last block. The next cycle clears pending and rd_gnt and enters IDLE.
- buf_rd_address, buf_rd_is_destructive and buf_read_write hold their last value when buf_enable=0.
- Only one grant is ever active; wr_gnt and rd_gnt are mutually exclusive.
- Capacity is checked only at grant time; the writer must not exceed wr_blocks.

Test Plan:
- Reset → all outputs 0 after one clock. Then wr_req=1, wr_blocks=3, buf_capacity=256 → wr_gnt=1 the next cycle. Drive 3 wr_valid with wr_last on the 3rd → buf_enable=1,buf_read_write=1 for exactly those 3 cycles; wr_gnt=0 on the following cycle.
- Reader 2: rd_addr=0x10, rd_destructive=1, rd_ready=1, 4-block chain (isLast on the 4th) → rd_gnt=4'b0100. RD_FIRST drives is_first=1, addr=0x10. rd_valid[2] is high for 4 cycles, and buf_enable=1 for 5 cycles total (including the commit). Then IDLE.
- Same chain with rd_ready[2] low for 3 cycles after block 2 → buf_enable=0 and rd_valid[2] held high during the stall; 4 blocks delivered in total with no duplicate enable.
- All rd_req=1 and wr_req=1, 1-block packets → grants rotate writer,R0,R1,R2,R3,writer.
- wr_blocks=10, buf_capacity=5, rd_req[0]=1 → R0 granted and writer skipped. After the capacity rises to 10, the writer is granted at the next IDLE.
- Reset asserted in RD at block 2 → next cycle all outputs 0 and state IDLE; a new request is granted normally.
